// File: rtl/calc_pkg.sv
// Shared types and constants for the 11-bit signed calculator datapath,
// including the 4-bit carry-lookahead slice used by the adder and divider.
package calc_pkg;

  localparam int unsigned CALC_WIDTH = 11;
  localparam logic [CALC_WIDTH-1:0] CALC_MOST_NEG = {1'b1, {(CALC_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } sdiv_state_t;

  // Sum of one 4-bit carry-lookahead slice.
  function automatic logic [3:0] cla4_sum(input logic [3:0] a, input logic [3:0] b,
                                          input logic cin);
    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;
    g    = a & b;
    p    = a ^ b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    return p ^ c;
  endfunction

  // Carry out of one 4-bit carry-lookahead slice.
  function automatic logic cla4_cout(input logic [3:0] a, input logic [3:0] b,
                                     input logic cin);
    logic [3:0] g;
    logic [3:0] p;
    g = a & b;
    p = a ^ b;
    return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
  endfunction

endpackage

// File: rtl/sdiv_step.sv
// One restoring shift-subtract step: shift in the next dividend bit, trial
// subtract the divisor magnitude through chained CLA slices, keep or restore.
module sdiv_step
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH = CALC_WIDTH
) (
  input  logic [WIDTH-1:0] p,
  input  logic             dvd_bit,
  input  logic [WIDTH-1:0] dmag,
  output logic [WIDTH-1:0] p_next_c,
  output logic             q_bit_c
);

  localparam int unsigned PW     = WIDTH + 1;
  localparam int unsigned NSLICE = (PW + 3) / 4;
  localparam int unsigned AW     = NSLICE * 4;

  logic [PW-1:0]     p_shift;
  logic [AW-1:0]     a_ext;
  logic [AW-1:0]     b_ext;
  logic [AW-1:0]     sum_ext;
  logic [NSLICE-1:0] carry;
  logic [PW-1:0]     trial;

  assign p_shift  = {p, dvd_bit};
  assign a_ext    = AW'(p_shift);
  assign b_ext    = ~AW'({1'b0, dmag});
  assign carry[0] = 1'b1;

  // P' - |divisor| as P' + ~{0,|divisor|} + 1, one CLA slice per nibble.
  for (genvar i = 0; i < int'(NSLICE); i++) begin : g_slice
    assign sum_ext[4*i +: 4] = cla4_sum(a_ext[4*i +: 4], b_ext[4*i +: 4], carry[i]);
    if (i < int'(NSLICE) - 1) begin : g_chain
      assign carry[i+1] = cla4_cout(a_ext[4*i +: 4], b_ext[4*i +: 4], carry[i]);
    end
  end

  assign trial    = sum_ext[PW-1:0];
  assign q_bit_c  = ~trial[PW-1];
  assign p_next_c = q_bit_c ? trial[WIDTH-1:0] : p_shift[WIDTH-1:0];

endmodule

// File: rtl/sdiv_seq.sv
// Sequential signed divider, one quotient bit per clock, START/BUSY/DONE
// handshake. Define SDIV_REM_OUT_EN to expose the signed remainder port.
module sdiv_seq
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH = CALC_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic             div_by_zero,
  output logic             overflow
`ifdef SDIV_REM_OUT_EN
  ,
  output logic [WIDTH-1:0] remainder
`endif
);

  localparam int unsigned      CW        = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MOST_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MINUS_ONE = '1;
  localparam logic [CW-1:0]    LAST_STEP = CW'(WIDTH - 1);

  sdiv_state_t      state;
  logic [CW-1:0]    cnt;
  // The partial remainder's top bit is always zero between steps (P < |divisor|),
  // so only the low WIDTH bits are held; the step widens it internally.
  logic [WIDTH-1:0] p_reg;
  logic [WIDTH-1:0] q_mag;
  logic [WIDTH-1:0] dmag;
  logic             dvd_neg;
  logic             dvs_neg;
  logic             ovf_case;
`ifdef SDIV_REM_OUT_EN
  logic [WIDTH-1:0] dvd_raw;
`endif

  logic             accept_c;
  logic [WIDTH-1:0] p_next_c;
  logic             q_bit_c;

  function automatic logic [WIDTH-1:0] twos_neg(input logic [WIDTH-1:0] x);
    return ~x + WIDTH'(1);
  endfunction

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? twos_neg(x) : x;
  endfunction

  assign accept_c = start && ((state == IDLE) || (state == DONE));

  sdiv_step #(.WIDTH(WIDTH)) u_step (
    .p        (p_reg),
    .dvd_bit  (q_mag[WIDTH-1]),
    .dmag     (dmag),
    .p_next_c (p_next_c),
    .q_bit_c  (q_bit_c)
  );

  // Control FSM, iteration datapath and registered results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      p_reg       <= '0;
      q_mag       <= '0;
      dmag        <= '0;
      dvd_neg     <= 1'b0;
      dvs_neg     <= 1'b0;
      ovf_case    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
`ifdef SDIV_REM_OUT_EN
      dvd_raw     <= '0;
      remainder   <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (accept_c) begin
        state    <= (divisor == '0) ? FIX : RUN;
        busy     <= 1'b1;
        cnt      <= '0;
        p_reg    <= '0;
        q_mag    <= magnitude(dividend);
        dmag     <= magnitude(divisor);
        dvd_neg  <= dividend[WIDTH-1];
        dvs_neg  <= divisor[WIDTH-1];
        ovf_case <= (dividend == MOST_NEG) && (divisor == MINUS_ONE);
`ifdef SDIV_REM_OUT_EN
        dvd_raw  <= dividend;
`endif
      end else begin
        case (state)
          IDLE: ;
          RUN: begin
            p_reg <= p_next_c;
            q_mag <= {q_mag[WIDTH-2:0], q_bit_c};
            cnt   <= cnt + CW'(1);
            if (cnt == LAST_STEP) state <= FIX;
          end
          FIX: begin
            // Most-negative / -1 wraps naturally: |q| = 2^(W-1) negates to itself.
            if (dmag == '0) quotient <= '0;
            else            quotient <= (dvd_neg ^ dvs_neg) ? twos_neg(q_mag) : q_mag;
`ifdef SDIV_REM_OUT_EN
            if (dmag == '0) remainder <= dvd_raw;
            else            remainder <= dvd_neg ? twos_neg(p_reg) : p_reg;
`endif
            div_by_zero <= (dmag == '0);
            overflow    <= ovf_case;
            busy        <= 1'b0;
            done        <= 1'b1;
            state       <= DONE;
          end
          DONE: state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sdiv_seq.sv
// Directed self-checking bench for sdiv_seq with hand-computed quotients,
// remainders (when SDIV_REM_OUT_EN is defined), flags and latencies.
module tb_sdiv_seq;
  import calc_pkg::*;

  localparam int unsigned W = CALC_WIDTH;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic         div_by_zero;
  logic         overflow;
`ifdef SDIV_REM_OUT_EN
  logic [W-1:0] remainder;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sdiv_seq #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
`ifdef SDIV_REM_OUT_EN
    ,
    .remainder   (remainder)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Present an operation for one edge, then scramble the operand inputs.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk); #1;
    start    = 1'b0;
    dividend = W'($urandom);
    divisor  = W'($urandom);
  endtask

  // Wait (bounded) for DONE; optionally pulse a 50/5 START at cycle 'poke'.
  task automatic wait_done(input int poke, output int lat, output logic busy_ok);
    lat     = -1;
    busy_ok = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      if (done) begin
        lat = c;
        if (busy) busy_ok = 1'b0;
        break;
      end
      if (!busy) busy_ok = 1'b0;
      if (c == poke) begin
        start    = 1'b1;
        dividend = W'(50);
        divisor  = W'(5);
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
  endtask

  task automatic op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                    input int exp_lat, input logic [W-1:0] exp_q, input logic [W-1:0] exp_r,
                    input logic exp_dz, input logic exp_ov, input int poke, input logic chain);
    int   lat;
    logic busy_ok;
    launch(a, b);
    wait_done(poke, lat, busy_ok);
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_busy"}, 32'(busy_ok), 32'd1);
    check({tag, "_quotient"}, 32'(quotient), 32'(exp_q));
    check({tag, "_div_by_zero"}, 32'(div_by_zero), 32'(exp_dz));
    check({tag, "_overflow"}, 32'(overflow), 32'(exp_ov));
`ifdef SDIV_REM_OUT_EN
    check({tag, "_remainder"}, 32'(remainder), 32'(exp_r));
`else
    if (exp_r != exp_r) $display("unreachable");
`endif
    if (!chain) begin
      @(posedge clk); #1;
      check({tag, "_done_pulse"}, 32'(done), 32'd0);
      check({tag, "_hold_q"}, 32'(quotient), 32'(exp_q));
    end
  endtask

  initial begin
    logic saw_done;
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_quotient", 32'(quotient), 32'd0);
    check("rst_flags", 32'({div_by_zero, overflow}), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    op("p100_d7",   W'(100),   W'(7),   13, W'(14),      W'(2),     1'b0, 1'b0, 0, 1'b0);
    op("m100_d7",   W'(-100),  W'(7),   13, W'('h7F2),   W'('h7FE), 1'b0, 1'b0, 0, 1'b0);
    op("p100_m7",   W'(100),   W'(-7),  13, W'('h7F2),   W'(2),     1'b0, 1'b0, 0, 1'b0);
    op("div_zero",  W'(5),     W'(0),   2,  W'(0),       W'(5),     1'b1, 1'b0, 0, 1'b0);
    op("p6_d3",     W'(6),     W'(3),   13, W'(2),       W'(0),     1'b0, 1'b0, 0, 1'b0);
    op("ovf",       W'(-1024), W'(-1),  13, W'('h400),   W'(0),     1'b0, 1'b1, 0, 1'b0);

    // Reset mid-run of 100/7 while outputs still hold the overflow result.
    launch(W'(100), W'(7));
    repeat (5) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_quotient", 32'(quotient), 32'd0);
    check("midrst_flags", 32'({div_by_zero, overflow}), 32'd0);
    check("midrst_state", 32'(dut.state), 32'(IDLE));
`ifdef SDIV_REM_OUT_EN
    check("midrst_remainder", 32'(remainder), 32'd0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    check("midrst_no_done", 32'(saw_done), 32'd0);
    op("p9_d2",     W'(9),     W'(2),   13, W'(4),       W'(1),     1'b0, 1'b0, 0, 1'b0);
    op("mneg_d1",   W'(-1024), W'(1),   13, W'('h400),   W'(0),     1'b0, 1'b0, 0, 1'b0);

    // Ignored START at cycle 4, then back-to-back accept in the DONE cycle.
    op("ignore",    W'(100),   W'(7),   13, W'(14),      W'(2),     1'b0, 1'b0, 4, 1'b1);
    op("b2b",       W'(50),    W'(5),   13, W'(10),      W'(0),     1'b0, 1'b0, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
